// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter and reservation gate in front of the register-cell array.
// Optional macro REGFILE_WB_BYPASS_EN: a write-back strobe this cycle releases a WAW stall on the same register.
module regfile_wb_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned W_OPR  = 32,
    parameter int unsigned N_REG  = 32,
    parameter int unsigned W_ADDR = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*W_ADDR-1:0]   req_addr_i,
    input  logic [N_REQ*W_OPR-1:0]    req_data_i,
    input  logic                      rsv_valid_i,
    input  logic [W_ADDR-1:0]         rsv_addr_i,
    input  logic [N_REG-1:0]          busy_res_i,
    output logic                      rsv_stall_o,
    output logic [N_REG-1:0]          w_reserve_o,
    output logic [N_REG-1:0]          wb_o,
    output logic [W_OPR-1:0]          wb_data_o
);

    localparam int unsigned W_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // One-hot cell select; r0 and out-of-range addresses decode to no cell.
    function automatic logic [N_REG-1:0] addr_onehot(input logic [W_ADDR-1:0] addr);
        logic [N_REG-1:0] v;
        v = '0;
        for (int r = 1; r < N_REG; r++) begin
            if (32'(addr) == 32'(r)) v[r] = 1'b1;
        end
        return v;
    endfunction

    logic [W_PTR-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REG-1:0]  wb_q, wb_d;
    logic [N_REG-1:0]  w_reserve_q, w_reserve_d;
    logic [W_OPR-1:0]  wb_data_q, wb_data_d;

    logic [N_REQ-1:0]  ready_c;
    logic              gnt_found;
    logic [W_PTR-1:0]  gnt_idx;
    logic [W_PTR-1:0]  scan_idx;
    logic [W_ADDR-1:0] gnt_addr;
    logic [W_OPR-1:0]  gnt_data;
    logic              rsv_hit;
    logic              rsv_stall;

    // First valid requester at or after rr_ptr wins; nothing is granted during reset.
    always_comb begin
        ready_c   = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = W_PTR'((32'(rr_ptr_q) + 32'(i)) % N_REQ);
            if (!rst && !gnt_found && req_valid_i[scan_idx]) begin
                gnt_found         = 1'b1;
                gnt_idx           = scan_idx;
                ready_c[scan_idx] = 1'b1;
                gnt_addr          = req_addr_i[32'(scan_idx)*W_ADDR +: W_ADDR];
                gnt_data          = req_data_i[32'(scan_idx)*W_OPR +: W_OPR];
            end
        end
    end

    // WAW gate: the decoded onehot already masks r0, so an r0 reservation never stalls.
    always_comb begin
        rsv_hit   = |(busy_res_i & addr_onehot(rsv_addr_i));
`ifdef REGFILE_WB_BYPASS_EN
        rsv_stall = !rst && rsv_valid_i && rsv_hit && !(|(wb_q & addr_onehot(rsv_addr_i)));
`else
        rsv_stall = !rst && rsv_valid_i && rsv_hit;
`endif
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wb_d        = '0;
        wb_data_d   = wb_data_q;
        w_reserve_d = '0;
        if (gnt_found) begin
            rr_ptr_d  = W_PTR'((32'(gnt_idx) + 32'd1) % N_REQ);
            wb_d      = addr_onehot(gnt_addr);
            wb_data_d = gnt_data;
        end
        if (rsv_valid_i && !rsv_stall) begin
            w_reserve_d = addr_onehot(rsv_addr_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wb_q        <= '0;
            w_reserve_q <= '0;
            wb_data_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wb_q        <= wb_d;
            w_reserve_q <= w_reserve_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign req_ready_o = ready_c;
    assign rsv_stall_o = rsv_stall;
    assign wb_o        = wb_q;
    assign w_reserve_o = w_reserve_q;
    assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-back strobes, reservations, reset.
module tb_regfile_wb_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned W_OPR  = 32;
    localparam int unsigned N_REG  = 32;
    localparam int unsigned W_ADDR = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req_valid_i;
    logic [N_REQ-1:0]         req_ready_o;
    logic [N_REQ*W_ADDR-1:0]  req_addr_i;
    logic [N_REQ*W_OPR-1:0]   req_data_i;
    logic                     rsv_valid_i;
    logic [W_ADDR-1:0]        rsv_addr_i;
    logic [N_REG-1:0]         busy_res_i;
    logic                     rsv_stall_o;
    logic [N_REG-1:0]         w_reserve_o;
    logic [N_REG-1:0]         wb_o;
    logic [W_OPR-1:0]         wb_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(
        .N_REQ(N_REQ), .W_OPR(W_OPR), .N_REG(N_REG), .W_ADDR(W_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i),
        .busy_res_i(busy_res_i), .rsv_stall_o(rsv_stall_o),
        .w_reserve_o(w_reserve_o), .wb_o(wb_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [W_ADDR-1:0] a, input logic [W_OPR-1:0] d);
        req_addr_i[k*W_ADDR +: W_ADDR] = a;
        req_data_i[k*W_OPR +: W_OPR]   = d;
    endtask

    function automatic logic [N_REG-1:0] bit_of(input int r);
        logic [N_REG-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    logic exp_stall_bypass;

    initial begin
`ifdef REGFILE_WB_BYPASS_EN
        exp_stall_bypass = 1'b0;
`else
        exp_stall_bypass = 1'b1;
`endif
        rst         = 1'b1;
        req_valid_i = 4'b1000;
        req_addr_i  = '0;
        req_data_i  = '0;
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd7;
        busy_res_i  = bit_of(7);
        set_req(3, 5'd3, 32'h0000_0033);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'h0);
        chk("rst_stall", 64'(rsv_stall_o), 64'h0);
        tick();
        chk("rst_wb", 64'(wb_o), 64'h0);
        chk("rst_wres", 64'(w_reserve_o), 64'h0);
        chk("rst_data", 64'(wb_data_o), 64'h0);

        // single request from unit 1
        rst         = 1'b0;
        rsv_valid_i = 1'b0;
        busy_res_i  = '0;
        req_valid_i = 4'b0010;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(req_ready_o), 64'h2);
        tick();
        req_valid_i = 4'b0000;
        chk("single_wb", 64'(wb_o), 64'(bit_of(5)));
        chk("single_data", 64'(wb_data_o), 64'hDEAD_BEEF);
        tick();
        chk("single_wb_drop", 64'(wb_o), 64'h0);
        chk("single_data_hold", 64'(wb_data_o), 64'hDEAD_BEEF);

        // pointer is 2; a lone unit-3 grant brings it to 0
        req_valid_i = 4'b1000;
        set_req(3, 5'd20, 32'h0000_0020);
        #1;
        chk("u3_ready", 64'(req_ready_o), 64'h8);
        tick();
        chk("u3_wb", 64'(wb_o), 64'(bit_of(20)));

        // all four valid for 8 cycles
        for (int k = 0; k < 4; k++) set_req(k, 5'(10 + k), 32'(32'hA0 + k));
        req_valid_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_ready_%0d", c), 64'(req_ready_o), 64'(4'b0001 << (c % 4)));
            tick();
            chk($sformatf("rr_wb_%0d", c), 64'(wb_o), 64'(bit_of(10 + c % 4)));
            chk($sformatf("rr_data_%0d", c), 64'(wb_data_o), 64'(32'hA0 + c % 4));
        end

        // unit 2 writes r0: handshake completes, no strobe
        req_valid_i = 4'b0100;
        set_req(2, 5'd0, 32'h0000_0055);
        #1;
        chk("r0_ready", 64'(req_ready_o), 64'h4);
        tick();
        chk("r0_wb", 64'(wb_o), 64'h0);
        chk("r0_data", 64'(wb_data_o), 64'h55);
        req_valid_i = 4'b1001;
        set_req(3, 5'd2, 32'h0000_0002);
        #1;
        chk("r0_ptr3_ready", 64'(req_ready_o), 64'h8);
        tick();
        chk("r0_ptr3_wb", 64'(wb_o), 64'(bit_of(2)));
        req_valid_i = 4'b0000;

        // reservation against a busy register, then a free one
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd7;
        busy_res_i  = bit_of(7);
        #1;
        chk("rsv_busy_stall", 64'(rsv_stall_o), 64'h1);
        tick();
        chk("rsv_busy_wres", 64'(w_reserve_o), 64'h0);
        busy_res_i = '0;
        #1;
        chk("rsv_free_stall", 64'(rsv_stall_o), 64'h0);
        tick();
        chk("rsv_free_wres", 64'(w_reserve_o), 64'(bit_of(7)));
        rsv_addr_i = 5'd0;
        busy_res_i = bit_of(0);
        #1;
        chk("rsv_r0_stall", 64'(rsv_stall_o), 64'h0);
        tick();
        chk("rsv_r0_wres", 64'(w_reserve_o), 64'h0);

        // reservation and write-back on r9 together
        busy_res_i  = '0;
        rsv_addr_i  = 5'd9;
        req_valid_i = 4'b0001;
        set_req(0, 5'd9, 32'h0000_0099);
        tick();
        chk("same_wb", 64'(wb_o), 64'(bit_of(9)));
        chk("same_wres", 64'(w_reserve_o), 64'(bit_of(9)));
        req_valid_i = 4'b0000;
        busy_res_i  = bit_of(9);
        #1;
        chk("bypass_stall", 64'(rsv_stall_o), 64'(exp_stall_bypass));
        tick();
        chk("bypass_wres", 64'(w_reserve_o), exp_stall_bypass ? 64'h0 : 64'(bit_of(9)));
        rsv_valid_i = 1'b0;
        busy_res_i  = '0;

        // reset with a strobe pending and unit 3 waiting
        req_valid_i = 4'b0010;
        set_req(1, 5'd12, 32'h0000_0077);
        tick();
        chk("pre_rst_wb", 64'(wb_o), 64'(bit_of(12)));
        rst         = 1'b1;
        req_valid_i = 4'b1000;
        set_req(3, 5'd13, 32'h0000_0013);
        #1;
        chk("mid_rst_ready", 64'(req_ready_o), 64'h0);
        tick();
        chk("mid_rst_wb", 64'(wb_o), 64'h0);
        chk("mid_rst_data", 64'(wb_data_o), 64'h0);
        rst         = 1'b0;
        req_valid_i = 4'b1010;
        #1;
        chk("post_rst_ptr0", 64'(req_ready_o), 64'h2);
        req_valid_i = 4'b1000;
        #1;
        chk("post_rst_u3_ready", 64'(req_ready_o), 64'h8);
        tick();
        chk("post_rst_u3_wb", 64'(wb_o), 64'(bit_of(13)));
        chk("post_rst_u3_data", 64'(wb_data_o), 64'h13);
        req_valid_i = 4'b0000;
        tick();
        chk("post_rst_idle", 64'(wb_o), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
